// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmitter (and, later, the receiver):
// FSM state encodings, bit-period counter width, the smallest usable
// divisor, and a helper that turns a clock rate and a baud rate into a
// saturated bit-period divisor.
// No ports (package).
// ---------------------------------------------------------------------------
package uart_pkg;

    // Width of the bit-period counter and of the latched divisor.
    localparam int DIV_W   = 16;

    // Smallest divisor that still gives a meaningful bit period.
    localparam int DIV_MIN = 2;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_STOP   = 3'd3,
        TX_PARITY = 3'd4
    } tx_state_t;

    // Clocks per bit = clk_hz / baud, clamped to what the counter can hold.
    // A zero baud yields zero, which the caller treats as "do not start".
    function automatic logic [DIV_W-1:0] calc_div(input logic [31:0] clk_hz,
                                                  input logic [31:0] baud);
        logic [31:0]      quot;
        logic [DIV_W-1:0] result;
        if (baud == 32'd0) begin
            quot = 32'd0;
        end else begin
            quot = clk_hz / baud;
        end
        if (quot > 32'(2**DIV_W - 1)) begin
            result = '1;
        end else begin
            result = quot[DIV_W-1:0];
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// ---------------------------------------------------------------------------
// uart_tx_if
// Byte write port of the UART transmitter (valid/ready handshake).
//   i_Tx_DV    : write strobe from the producer
//   i_Tx_Byte  : byte to transmit
//   o_Tx_Ready : transmitter can accept a byte (FIFO not full)
// master = producer side, slave = transmitter side.
// ---------------------------------------------------------------------------
interface uart_tx_if;

    logic       i_Tx_DV;
    logic [7:0] i_Tx_Byte;
    logic       o_Tx_Ready;

    modport master (
        output i_Tx_DV,
        output i_Tx_Byte,
        input  o_Tx_Ready
    );

    modport slave (
        input  i_Tx_DV,
        input  i_Tx_Byte,
        output o_Tx_Ready
    );

endinterface

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
// Synchronous byte FIFO with asynchronous active-low reset.
//   i_Clock, i_Reset_n : clock, async active-low reset (empties the FIFO)
//   i_wr_en, i_din     : push request and data; ignored while full
//   i_rd_en            : pop request; ignored while empty
//   o_dout             : head entry (valid while !o_empty)
//   o_empty, o_full    : occupancy flags, derived from registered pointers
// DEPTH must be a power of two.
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       i_Clock,
    input  logic       i_Reset_n,
    input  logic       i_wr_en,
    input  logic [7:0] i_din,
    input  logic       i_rd_en,
    output logic [7:0] o_dout,
    output logic       o_empty,
    output logic       o_full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [7:0] r_mem [DEPTH];
    logic [AW:0] r_wrPtr;
    logic [AW:0] r_rdPtr;
    logic        w_wr;
    logic        w_rd;

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    assign w_wr    = i_wr_en && !o_full;
    assign w_rd    = i_rd_en && !o_empty;
    assign o_empty = (r_wrPtr == r_rdPtr);
    assign o_full  = (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]) &&
                     (r_wrPtr[AW] != r_rdPtr[AW]);
    assign o_dout  = r_mem[r_rdPtr[AW-1:0]];

    // Pointer update; a push and a pop in the same cycle both take effect.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_wr) begin
                r_wrPtr <= r_wrPtr + PTR_ONE;
            end
            if (w_rd) begin
                r_rdPtr <= r_rdPtr + PTR_ONE;
            end
        end
    end

    // Storage needs no reset: nothing is read until a pointer moves past it.
    always_ff @(posedge i_Clock) begin
        if (w_wr) begin
            r_mem[r_wrPtr[AW-1:0]] <= i_din;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx
// UART transmitter, 8 data bits LSB first, one start and one stop bit.
// Bytes are queued in a small FIFO and serialised with a bit period of
// CLK_FREQ_HZ/baudrate clocks, latched at the start of every frame.
// Ports:
//   i_Clock, i_Reset_n : clock, async active-low reset
//   baudrate           : requested baud rate (0 or too fast = hold off)
//   tx_if (slave)      : byte write port i_Tx_DV / i_Tx_Byte / o_Tx_Ready
//   o_Tx_Serial        : serial line, idle high
//   o_Tx_Active        : high for the whole frame, start through stop
//   o_Tx_Done          : one-clock pulse after the stop bit
// Build option UART_TX_PARITY_EN: adds i_Parity_Odd and a parity bit
// between the data and the stop bit.
// ---------------------------------------------------------------------------
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 16_000_000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        i_Clock,
    input  logic        i_Reset_n,
    input  logic [31:0] baudrate,
`ifdef UART_TX_PARITY_EN
    input  logic        i_Parity_Odd,
`endif
    uart_tx_if.slave    tx_if,
    output logic        o_Tx_Serial,
    output logic        o_Tx_Active,
    output logic        o_Tx_Done
);

    localparam logic [DIV_W-1:0] CNT_ONE = DIV_W'(1);

    tx_state_t        r_state,  w_stateNext;
    logic [7:0]       r_shift,  w_shiftNext;
    logic [DIV_W-1:0] r_div,    w_divNext;
    logic [DIV_W-1:0] r_cnt,    w_cntNext;
    logic [2:0]       r_bitIdx, w_bitIdxNext;
    logic             r_serial, w_serialNext;
    logic             r_active, w_activeNext;
    logic             r_done,   w_doneNext;
`ifdef UART_TX_PARITY_EN
    logic             r_parity, w_parityNext;
`endif
    logic [DIV_W-1:0] w_divCalc;
    logic             w_divOk;
    logic             w_bitEnd;
    logic             w_pop;
    logic [7:0]       w_fifoDout;
    logic             w_fifoEmpty;
    logic             w_fifoFull;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_Clock   (i_Clock),
        .i_Reset_n (i_Reset_n),
        .i_wr_en   (tx_if.i_Tx_DV),
        .i_din     (tx_if.i_Tx_Byte),
        .i_rd_en   (w_pop),
        .o_dout    (w_fifoDout),
        .o_empty   (w_fifoEmpty),
        .o_full    (w_fifoFull)
    );

    assign tx_if.o_Tx_Ready = !w_fifoFull;

    assign w_divCalc = calc_div(32'(CLK_FREQ_HZ), baudrate);
    assign w_divOk   = (w_divCalc >= DIV_W'(DIV_MIN));
    assign w_bitEnd  = (r_cnt == r_div - CNT_ONE);

    assign o_Tx_Serial = r_serial;
    assign o_Tx_Active = r_active;
    assign o_Tx_Done   = r_done;

    // All FSM state and the line outputs are registered here; the async
    // reset forces the line idle immediately, abandoning any frame.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_state  <= TX_IDLE;
            r_shift  <= '0;
            r_div    <= '0;
            r_cnt    <= '0;
            r_bitIdx <= '0;
            r_serial <= 1'b1;
            r_active <= 1'b0;
            r_done   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            r_state  <= w_stateNext;
            r_shift  <= w_shiftNext;
            r_div    <= w_divNext;
            r_cnt    <= w_cntNext;
            r_bitIdx <= w_bitIdxNext;
            r_serial <= w_serialNext;
            r_active <= w_activeNext;
            r_done   <= w_doneNext;
`ifdef UART_TX_PARITY_EN
            r_parity <= w_parityNext;
`endif
        end
    end

    // Next-state logic. Every line level is computed one clock ahead so the
    // serial output comes straight from a flop. The shift register moves
    // right at each data-bit boundary, so r_shift[1] is always the next bit.
    always_comb begin
        w_stateNext  = r_state;
        w_shiftNext  = r_shift;
        w_divNext    = r_div;
        w_cntNext    = r_cnt;
        w_bitIdxNext = r_bitIdx;
        w_serialNext = r_serial;
        w_activeNext = r_active;
        w_doneNext   = 1'b0;
        w_pop        = 1'b0;
`ifdef UART_TX_PARITY_EN
        w_parityNext = r_parity;
`endif
        case (r_state)
            TX_IDLE: begin
                w_serialNext = 1'b1;
                w_activeNext = 1'b0;
                w_cntNext    = '0;
                w_bitIdxNext = '0;
                if (!w_fifoEmpty && w_divOk) begin
                    w_pop        = 1'b1;
                    w_shiftNext  = w_fifoDout;
                    w_divNext    = w_divCalc;
                    w_serialNext = 1'b0;
                    w_activeNext = 1'b1;
                    w_stateNext  = TX_START;
`ifdef UART_TX_PARITY_EN
                    w_parityNext = (^w_fifoDout) ^ i_Parity_Odd;
`endif
                end
            end
            TX_START: begin
                if (w_bitEnd) begin
                    w_cntNext    = '0;
                    w_serialNext = r_shift[0];
                    w_stateNext  = TX_DATA;
                end else begin
                    w_cntNext = r_cnt + CNT_ONE;
                end
            end
            TX_DATA: begin
                if (w_bitEnd) begin
                    w_cntNext = '0;
                    if (r_bitIdx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_serialNext = r_parity;
                        w_stateNext  = TX_PARITY;
`else
                        w_serialNext = 1'b1;
                        w_stateNext  = TX_STOP;
`endif
                    end else begin
                        w_bitIdxNext = r_bitIdx + 3'd1;
                        w_serialNext = r_shift[1];
                        w_shiftNext  = {1'b0, r_shift[7:1]};
                    end
                end else begin
                    w_cntNext = r_cnt + CNT_ONE;
                end
            end
`ifdef UART_TX_PARITY_EN
            TX_PARITY: begin
                if (w_bitEnd) begin
                    w_cntNext    = '0;
                    w_serialNext = 1'b1;
                    w_stateNext  = TX_STOP;
                end else begin
                    w_cntNext = r_cnt + CNT_ONE;
                end
            end
`endif
            TX_STOP: begin
                if (w_bitEnd) begin
                    w_cntNext    = '0;
                    w_doneNext   = 1'b1;
                    w_activeNext = 1'b0;
                    w_stateNext  = TX_IDLE;
                end else begin
                    w_cntNext = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_stateNext  = TX_IDLE;
                w_serialNext = 1'b1;
                w_activeNext = 1'b0;
                w_cntNext    = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx
// Self-checking bench for uart_tx. A monitor logs the line outputs after
// every rising edge; each test then compares the logged window against a
// frame-level model (start bit, data LSB first, optional parity, stop bit,
// each lasting CLK_HZ/baud clocks). Honours UART_TX_PARITY_EN.
// ---------------------------------------------------------------------------
module tb_uart_tx;

    localparam int CLK_HZ = 16_000_000;
    localparam int MAXC   = 32768;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic        clk;
    logic        rstN;
    logic [31:0] baud;
    logic        parOdd;
    logic        serial;
    logic        active;
    logic        done;

    int nChecks = 0;
    int nFails  = 0;
    int cyc     = 0;

    // logv[k] = {serial, active, done, ready} after rising edge k
    logic [3:0] logv [MAXC];

    uart_tx_if txIf ();

    uart_tx #(
        .CLK_FREQ_HZ (CLK_HZ),
        .FIFO_DEPTH  (4)
    ) dut (
        .i_Clock      (clk),
        .i_Reset_n    (rstN),
        .baudrate     (baud),
`ifdef UART_TX_PARITY_EN
        .i_Parity_Odd (parOdd),
`endif
        .tx_if        (txIf),
        .o_Tx_Serial  (serial),
        .o_Tx_Active  (active),
        .o_Tx_Done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter advances on each rising edge; the log is filled at the
    // following falling edge, well away from the edge that changed it.
    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (cyc < MAXC) logv[cyc] = {serial, active, done, txIf.o_Tx_Ready};
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, cyc=%0d required<%0d", cyc, MAXC);
        $fatal(1, "[TB] watchdog expired");
    end

    // Expected {serial, active, done} at offset t from the first start-bit
    // clock of a frame, including the idle clocks that follow it.
    function automatic logic [2:0] expTriple(input logic [7:0] b, input int d,
                                             input logic par, input int t);
        int   k;
        logic s;
        if (t >= NB * d) return {1'b1, 1'b0, (t == NB * d)};
        k = t / d;
        if (k == 0)                 s = 1'b0;
        else if (k <= 8)            s = b[k-1];
        else if (k == 9 && NB == 11) s = par;
        else                        s = 1'b1;
        return {s, 1'b1, 1'b0};
    endfunction

    function automatic logic expPar(input logic [7:0] b, input logic odd);
        return (^b) ^ odd;
    endfunction

    // Push one byte; s returns the log index of the first start-bit clock
    // if the transmitter was idle with an empty FIFO.
    task automatic push(input logic [7:0] b, output int s);
        @(negedge clk);
        txIf.i_Tx_DV   = 1'b1;
        txIf.i_Tx_Byte = b;
        s = cyc + 2;
        @(negedge clk);
        txIf.i_Tx_DV = 1'b0;
    endtask

    task automatic waitCyc(input int target);
        while (cyc <= target) @(negedge clk);
    endtask

    task automatic test_reset();
        #2 rstN = 1'b0;
        #1;
        nChecks++;
        if ({serial, active, done, txIf.o_Tx_Ready} !== 4'b1001) begin
            nFails++;
            $display("[TB] FAIL reset_outputs: got %b required 1001", {serial, active, done, txIf.o_Tx_Ready});
        end
        repeat (3) @(negedge clk);
        rstN = 1'b1;
        repeat (2) @(negedge clk);
        nChecks++;
        if ({serial, active, done, txIf.o_Tx_Ready} !== 4'b1001) begin
            nFails++;
            $display("[TB] FAIL reset_idle: got %b required 1001", {serial, active, done, txIf.o_Tx_Ready});
        end
    endtask

    task automatic test_frame_55();
        int   s;
        logic p;
        baud = 1_000_000;
        parOdd = 1'b0;
        p = expPar(8'h55, parOdd);
        push(8'h55, s);
        waitCyc(s + NB * 16 + 3);
        for (int t = 0; t <= NB * 16 + 3; t++) begin
            nChecks++;
            if (logv[s+t][3:1] !== expTriple(8'h55, 16, p, t)) begin
                nFails++;
                $display("[TB] FAIL frame55 t=%0d: got %b required %b", t, logv[s+t][3:1], expTriple(8'h55, 16, p, t));
            end
        end
    endtask

    task automatic test_random_frames();
        int          bauds [4] = '{1_000_000, 500_000, 250_000, 115_200};
        int          s;
        int          d;
        logic [7:0]  b;
        logic        p;
        for (int n = 0; n < 4; n++) begin
            baud   = bauds[$urandom_range(0, 3)];
            d      = CLK_HZ / baud;
            b      = 8'($urandom);
            parOdd = 1'($urandom);
            p      = expPar(b, parOdd);
            push(b, s);
            waitCyc(s + NB * d + 2);
            for (int t = 0; t <= NB * d + 2; t++) begin
                nChecks++;
                if (logv[s+t][3:1] !== expTriple(b, d, p, t)) begin
                    nFails++;
                    $display("[TB] FAIL random_frame b=%h d=%0d t=%0d: got %b required %b", b, d, t, logv[s+t][3:1], expTriple(b, d, p, t));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
        int s;
        int s0;
        int flen;
        parOdd = 1'b0;
        baud   = 0;
        for (int i = 0; i < 4; i++) push(bytes[i], s);
        nChecks++;
        if (txIf.o_Tx_Ready !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL b2b_full_ready: got %b required 0", txIf.o_Tx_Ready);
        end
        push(8'h5A, s);
        nChecks++;
        if (txIf.o_Tx_Ready !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL b2b_drop_ready: got %b required 0", txIf.o_Tx_Ready);
        end
        @(negedge clk);
        baud = 1_000_000;
        s0   = cyc + 1;
        flen = NB * 16;
        waitCyc(s0 + 4 * (flen + 1) + 200);
        nChecks++;
        if (logv[s0][0] !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL b2b_ready_after_pop: got %b required 1", logv[s0][0]);
        end
        for (int f = 0; f < 4; f++) begin
            for (int t = 0; t <= flen; t++) begin
                nChecks++;
                if (logv[s0 + f*(flen+1) + t][3:1] !== expTriple(bytes[f], 16, expPar(bytes[f], 1'b0), t)) begin
                    nFails++;
                    $display("[TB] FAIL b2b_frame%0d t=%0d: got %b required %b", f, t,
                             logv[s0 + f*(flen+1) + t][3:1], expTriple(bytes[f], 16, expPar(bytes[f], 1'b0), t));
                end
            end
        end
        for (int t = 4 * (flen + 1); t < 4 * (flen + 1) + 200; t++) begin
            nChecks++;
            if (logv[s0+t] !== 4'b1001) begin
                nFails++;
                $display("[TB] FAIL b2b_idle_after t=%0d: got %b required 1001", t, logv[s0+t]);
            end
        end
    endtask

    task automatic test_baud_change();
        int         s;
        int         s2;
        int         dummy;
        logic [7:0] b2;
        parOdd = 1'b0;
        baud   = 1_000_000;
        b2     = 8'($urandom);
        push(8'hA3, s);
        push(b2, dummy);
        waitCyc(s + 49);
        baud = 500_000;
        s2   = s + NB * 16 + 1;
        waitCyc(s2 + NB * 32 + 2);
        for (int t = 0; t <= NB * 16; t++) begin
            nChecks++;
            if (logv[s+t][3:1] !== expTriple(8'hA3, 16, expPar(8'hA3, 1'b0), t)) begin
                nFails++;
                $display("[TB] FAIL baudchg_first t=%0d: got %b required %b", t, logv[s+t][3:1], expTriple(8'hA3, 16, expPar(8'hA3, 1'b0), t));
            end
        end
        for (int t = 0; t <= NB * 32 + 2; t++) begin
            nChecks++;
            if (logv[s2+t][3:1] !== expTriple(b2, 32, expPar(b2, 1'b0), t)) begin
                nFails++;
                $display("[TB] FAIL baudchg_second t=%0d: got %b required %b", t, logv[s2+t][3:1], expTriple(b2, 32, expPar(b2, 1'b0), t));
            end
        end
    endtask

    task automatic test_baud_invalid();
        int s;
        int c;
        parOdd = 1'b0;
        baud   = 0;
        push(8'h7E, s);
        c = cyc;
        waitCyc(c + 1000);
        baud = 10_000_000;
        waitCyc(c + 1100);
        for (int i = c; i < c + 1100; i++) begin
            nChecks++;
            if (logv[i][3:1] !== 3'b100) begin
                nFails++;
                $display("[TB] FAIL baud_invalid cyc=%0d: got %b required 100", i, logv[i][3:1]);
            end
        end
        baud = 1_000_000;
        s    = cyc + 1;
        waitCyc(s + NB * 16 + 2);
        for (int t = 0; t <= NB * 16 + 2; t++) begin
            nChecks++;
            if (logv[s+t][3:1] !== expTriple(8'h7E, 16, expPar(8'h7E, 1'b0), t)) begin
                nFails++;
                $display("[TB] FAIL baud_valid_frame t=%0d: got %b required %b", t, logv[s+t][3:1], expTriple(8'h7E, 16, expPar(8'h7E, 1'b0), t));
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int         s;
        int         dummy;
        int         c;
        logic [7:0] b1;
        baud = 1_000_000;
        b1   = 8'($urandom);
        push(b1, s);
        push(8'($urandom), dummy);
        push(8'($urandom), dummy);
        waitCyc(s + 4 * 16 + 4);
        nChecks++;
        if (serial !== b1[3]) begin
            nFails++;
            $display("[TB] FAIL midframe_bit3: got %b required %b", serial, b1[3]);
        end
        #2 rstN = 1'b0;
        #1;
        nChecks++;
        if ({serial, active, done, txIf.o_Tx_Ready} !== 4'b1001) begin
            nFails++;
            $display("[TB] FAIL midframe_reset_immediate: got %b required 1001", {serial, active, done, txIf.o_Tx_Ready});
        end
        @(negedge clk);
        rstN = 1'b1;
        c    = cyc;
        waitCyc(c + 301);
        for (int i = c + 1; i <= c + 300; i++) begin
            nChecks++;
            if (logv[i] !== 4'b1001) begin
                nFails++;
                $display("[TB] FAIL after_reset_idle cyc=%0d: got %b required 1001", i, logv[i]);
            end
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        int s;
        for (int k = 0; k < 2; k++) begin
            baud   = 1_000_000;
            parOdd = 1'(k);
            push(8'h07, s);
            waitCyc(s + 176 + 2);
            nChecks++;
            if (logv[s + 9*16 + 5][3] !== (k == 0 ? 1'b1 : 1'b0)) begin
                nFails++;
                $display("[TB] FAIL parity_bit odd=%0d: got %b required %b", k, logv[s + 9*16 + 5][3], (k == 0 ? 1'b1 : 1'b0));
            end
            for (int t = 0; t <= 178; t++) begin
                nChecks++;
                if (logv[s+t][3:1] !== expTriple(8'h07, 16, expPar(8'h07, parOdd), t)) begin
                    nFails++;
                    $display("[TB] FAIL parity_frame odd=%0d t=%0d: got %b required %b", k, t, logv[s+t][3:1], expTriple(8'h07, 16, expPar(8'h07, parOdd), t));
                end
            end
        end
    endtask
`endif

    initial begin
        rstN           = 1'b1;
        baud           = 1_000_000;
        parOdd         = 1'b0;
        txIf.i_Tx_DV   = 1'b0;
        txIf.i_Tx_Byte = 8'h00;
        test_reset();
        test_frame_55();
        test_random_frames();
        test_back_to_back();
        test_baud_change();
        test_baud_invalid();
        test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
